// File: rtl/alu_seq_pkg.sv
// Shared opcodes, IR field positions, FSM states and instruction classes for alu_sequencer.
// ALU_SEQ_MULDIV_EN adds the EX6 state used by the MUL/DIV sequence.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_EX3,
    S_EX4,
    S_EX5,
`ifdef ALU_SEQ_MULDIV_EN
    S_EX6,
`endif
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL,
    CLS_THREE,
    CLS_UNARY,
    CLS_MULDIV
  } instrClass_t;

endpackage

// File: rtl/alu_seq_if.sv
// DataPath control bundle: strobes, register selects and ALU opcode out, IR contents back in.
interface alu_seq_if #(
  parameter int N_REGS = 16
);
  logic              PCout;
  logic              IncPC;
  logic              MARin;
  logic              Zin;
  logic              PCin;
  logic              Read;
  logic              MDRin;
  logic              MDRout;
  logic              IRin;
  logic              Yin;
  logic              Zlo_out;
  logic              Zhi_out;
  logic              HIin;
  logic              LOin;
  logic [N_REGS-1:0] Rin;
  logic [N_REGS-1:0] Rout;
  logic [4:0]        opcode;
  logic [31:0]       IR_VALUE;

  modport master (
    output PCout, IncPC, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
           Zlo_out, Zhi_out, HIin, LOin, Rin, Rout, opcode,
    input  IR_VALUE
  );

  modport slave (
    input  PCout, IncPC, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
           Zlo_out, Zhi_out, HIin, LOin, Rin, Rout, opcode,
    output IR_VALUE
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational IR decode: instruction class, opcode field and one-hot register selects.
// MUL/DIV decode as illegal unless ALU_SEQ_MULDIV_EN is defined.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int N_REGS = 16
) (
  input  logic [31:0]       i_ir,
  output instrClass_t       o_class,
  output logic [4:0]        o_opcode,
  output logic [N_REGS-1:0] o_raSel,
  output logic [N_REGS-1:0] o_rbSel,
  output logic [N_REGS-1:0] o_rcSel
);

  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;

  // Indices at or beyond N_REGS select no register at all.
  function automatic logic [N_REGS-1:0] oneHot(input logic [3:0] idx);
    logic [N_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (int'(idx) == i) begin
        sel[i] = 1'b1;
      end
    end
    return sel;
  endfunction

  assign o_opcode = i_ir[IR_OP_MSB:IR_OP_LSB];
  assign w_ra     = i_ir[IR_RA_MSB:IR_RA_LSB];
  assign w_rb     = i_ir[IR_RB_MSB:IR_RB_LSB];
  assign w_rc     = i_ir[IR_RC_MSB:IR_RC_LSB];

  assign o_raSel = oneHot(w_ra);
  assign o_rbSel = oneHot(w_rb);
  assign o_rcSel = oneHot(w_rc);

  always_comb begin
    o_class = CLS_ILLEGAL;
    case (o_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: o_class = CLS_THREE;
      OP_NEG, OP_NOT:                 o_class = CLS_UNARY;
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL, OP_DIV:                 o_class = CLS_MULDIV;
`endif
      OP_NOP:                         o_class = CLS_NOP;
      OP_HALT:                        o_class = CLS_HALT;
      default:                        o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired fetch/execute control unit driving the DataPath strobes one T-state per clock.
// Define ALU_SEQ_MULDIV_EN to compile in the MUL/DIV sequence (EX5/EX6 with LOin/HIin).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N_REGS = 16
) (
  input  logic      clock,
  input  logic      clear,
  input  logic      run,
  input  logic      mem_ready,
  alu_seq_if.master dp,
  output logic      halted,
  output logic      illegal
);

  state_t            r_state;
  state_t            w_nextState;
  state_t            w_endState;
  logic              r_prevFetch1;
  instrClass_t       w_class;
  logic [4:0]        w_opcode;
  logic [N_REGS-1:0] w_raSel;
  logic [N_REGS-1:0] w_rbSel;
  logic [N_REGS-1:0] w_rcSel;

  alu_seq_decode #(.N_REGS(N_REGS)) u_decode (
    .i_ir     (dp.IR_VALUE),
    .o_class  (w_class),
    .o_opcode (w_opcode),
    .o_raSel  (w_raSel),
    .o_rbSel  (w_rbSel),
    .o_rcSel  (w_rcSel)
  );

  // r_prevFetch1 marks FETCH1 wait cycles so PCin fires only on entry.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state      <= S_IDLE;
      r_prevFetch1 <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_prevFetch1 <= (r_state == S_FETCH1);
    end
  end

  assign w_endState = run ? S_FETCH0 : S_IDLE;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (run) w_nextState = S_FETCH0;
      S_FETCH0: w_nextState = S_FETCH1;
      S_FETCH1: if (mem_ready) w_nextState = S_FETCH2;
      S_FETCH2: w_nextState = S_EX3;
      S_EX3: begin
        case (w_class)
          CLS_THREE, CLS_UNARY, CLS_MULDIV: w_nextState = S_EX4;
          CLS_HALT:                         w_nextState = S_HALT;
          default:                          w_nextState = w_endState;
        endcase
      end
      S_EX4:    w_nextState = (w_class == CLS_UNARY) ? w_endState : S_EX5;
`ifdef ALU_SEQ_MULDIV_EN
      S_EX5:    w_nextState = (w_class == CLS_MULDIV) ? S_EX6 : w_endState;
      S_EX6:    w_nextState = w_endState;
`else
      S_EX5:    w_nextState = w_endState;
`endif
      S_HALT:   w_nextState = S_HALT;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state registers and the stable IR contents.
  always_comb begin
    dp.PCout   = 1'b0;
    dp.IncPC   = 1'b0;
    dp.MARin   = 1'b0;
    dp.Zin     = 1'b0;
    dp.PCin    = 1'b0;
    dp.Read    = 1'b0;
    dp.MDRin   = 1'b0;
    dp.MDRout  = 1'b0;
    dp.IRin    = 1'b0;
    dp.Yin     = 1'b0;
    dp.Zlo_out = 1'b0;
    dp.Zhi_out = 1'b0;
    dp.HIin    = 1'b0;
    dp.LOin    = 1'b0;
    dp.Rin     = '0;
    dp.Rout    = '0;
    dp.opcode  = 5'd0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH0: begin
        dp.PCout = 1'b1;
        dp.IncPC = 1'b1;
        dp.MARin = 1'b1;
        dp.Zin   = 1'b1;
      end
      S_FETCH1: begin
        dp.Zlo_out = 1'b1;
        dp.PCin    = ~r_prevFetch1;
        dp.Read    = 1'b1;
        dp.MDRin   = 1'b1;
      end
      S_FETCH2: begin
        dp.MDRout = 1'b1;
        dp.IRin   = 1'b1;
      end
      S_EX3: begin
        case (w_class)
          CLS_THREE: begin
            dp.Rout = w_rbSel;
            dp.Yin  = 1'b1;
          end
          CLS_UNARY: begin
            dp.Rout   = w_rbSel;
            dp.opcode = w_opcode;
            dp.Zin    = 1'b1;
          end
`ifdef ALU_SEQ_MULDIV_EN
          CLS_MULDIV: begin
            dp.Rout = w_raSel;
            dp.Yin  = 1'b1;
          end
`endif
          CLS_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_EX4: begin
        case (w_class)
          CLS_THREE: begin
            dp.Rout   = w_rcSel;
            dp.opcode = w_opcode;
            dp.Zin    = 1'b1;
          end
          CLS_UNARY: begin
            dp.Zlo_out = 1'b1;
            dp.Rin     = w_raSel;
          end
`ifdef ALU_SEQ_MULDIV_EN
          CLS_MULDIV: begin
            dp.Rout   = w_rbSel;
            dp.opcode = w_opcode;
            dp.Zin    = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_EX5: begin
        case (w_class)
          CLS_THREE: begin
            dp.Zlo_out = 1'b1;
            dp.Rin     = w_raSel;
          end
`ifdef ALU_SEQ_MULDIV_EN
          CLS_MULDIV: begin
            dp.Zlo_out = 1'b1;
            dp.LOin    = 1'b1;
          end
`endif
          default: ;
        endcase
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_EX6: begin
        dp.Zhi_out = 1'b1;
        dp.HIin    = 1'b1;
      end
`endif
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
